btn_debounce: RTL and testbench

//  Conditions raw push-button inputs for the data-entry stage. Per channel: 2-flop synchronise,

---
 rtl/btn_pkg.sv | 26 ++
 rtl/btn_debounce_ch.sv | 153 +++++++++++++++
 rtl/btn_debounce.sv | 36 +++
 tb/tb_btn_debounce.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning slice:
// channel state encoding, default cycle counts and the counter-width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEF_N_BTN           = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms at 100 MHz
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    // Width able to hold the largest terminal count (max - 1); never below 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with saturating counter,
// registered level and one-clock press/release pulses. Auto-repeat when AUTO_REPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic          btn_sync;
    btn_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          level_reg, level_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic          repeat_fire;

    assign btn_sync = sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg    <= 2'b00;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], btn_raw};
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    // The counter leaves its wait state on reaching DB_LAST, so it never wraps.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (btn_sync) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next = HELD;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end else begin
                    press_next = repeat_fire;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_next = HELD;
                end else if (cnt_reg == DB_LAST) begin
                    state_next   = IDLE;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] rcnt_reg, rcnt_next;
    logic          rphase_reg, rphase_next;   // 0: waiting first delay, 1: periodic

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_reg   <= '0;
            rphase_reg <= 1'b0;
        end else begin
            rcnt_reg   <= rcnt_next;
            rphase_reg <= rphase_next;
        end
    end

    // Cleared outside a hold so it starts from zero at the press edge;
    // RELEASE_WAIT leaves it untouched so a bounce back to HELD resumes it.
    always_comb begin
        rcnt_next   = rcnt_reg;
        rphase_next = rphase_reg;
        repeat_fire = 1'b0;
        case (state_reg)
            IDLE, PRESS_WAIT: begin
                rcnt_next   = '0;
                rphase_next = 1'b0;
            end
            HELD: begin
                if (btn_sync) begin
                    if (rcnt_reg == (rphase_reg ? RP_LAST : RD_LAST)) begin
                        repeat_fire = 1'b1;
                        rcnt_next   = '0;
                        rphase_next = 1'b1;
                    end else begin
                        rcnt_next = rcnt_reg + CW'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: N_BTN independent debounced channels producing a clean level bus
// and press/release pulses. Define AUTO_REPEAT_EN to get repeated press pulses while held.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .btn_raw     (btn_raw[gi]),
                .btn_level   (btn_level[gi]),
                .btn_press   (btn_press[gi]),
                .btn_release (btn_release[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with short debounce/repeat counts.
// Raw inputs change just after a clock edge; the next edge is the first to sample them.
module tb_btn_debounce;

    localparam int N_BTN = 5;
    localparam int DEB   = 8;
    localparam int RD    = 20;
    localparam int RP    = 10;
    localparam int LAT   = 2 + DEB;   // edges after the first sampling edge until output changes

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [N_BTN-1:0] btn_level, btn_press, btn_release;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expects silence on the chosen pulse bus until edge LAT, the mask there, then silence again.
    task automatic wait_pulse(input string tag, input bit is_rel, input logic [N_BTN-1:0] mask);
        logic [N_BTN-1:0] v;
        for (int i = 0; i <= LAT; i++) begin
            tick();
            v = is_rel ? btn_release : btn_press;
            if (i < LAT) check({tag, "_early"}, 32'(v), 32'(0));
            else         check(tag, 32'(v), 32'(mask));
        end
        tick();
        v = is_rel ? btn_release : btn_press;
        check({tag, "_width"}, 32'(v), 32'(0));
    endtask

    initial begin
        logic [N_BTN-1:0] exp_p;

        // Reset state
        tick(3);
        check("rst_level",   32'(btn_level),   32'(0));
        check("rst_press",   32'(btn_press),   32'(0));
        check("rst_release", 32'(btn_release), 32'(0));
        rst = 1'b0;
        tick(2);

        // 1. Clean press on channel 0 only
        btn_raw = 5'b00001;
        wait_pulse("t1_press", 1'b0, 5'b00001);
        check("t1_level", 32'(btn_level), 32'(5'b00001));

        // 3b. 5-clk low glitch while held: no release
        btn_raw = 5'b00000;
        tick(5);
        btn_raw = 5'b00001;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t3_glitch_rel", 32'(btn_release), 32'(0));
            check("t3_glitch_lvl", 32'(btn_level),   32'(5'b00001));
        end

        // 3a. Clean release
        btn_raw = 5'b00000;
        wait_pulse("t3_release", 1'b1, 5'b00001);
        check("t3_level", 32'(btn_level), 32'(0));
        tick(3);

        // 2. Bounce 1,0,1 at 3-clk spacing, then hold
        btn_raw = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_bounce_hi", 32'(btn_press), 32'(0));
        end
        btn_raw = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_bounce_lo", 32'(btn_press), 32'(0));
        end
        btn_raw = 5'b00001;
        wait_pulse("t2_press", 1'b0, 5'b00001);
        check("t2_level", 32'(btn_level), 32'(5'b00001));
        btn_raw = 5'b00000;
        wait_pulse("t2_release", 1'b1, 5'b00001);
        tick(3);

        // 4. Reset at the 4th clock of PRESS_WAIT, raw held high
        btn_raw = 5'b00010;
        tick(6);
        rst = 1'b1;
        tick();
        check("t4_rst_level", 32'(btn_level),   32'(0));
        check("t4_rst_press", 32'(btn_press),   32'(0));
        check("t4_rst_rel",   32'(btn_release), 32'(0));
        rst = 1'b0;
        wait_pulse("t4_press", 1'b0, 5'b00010);
        check("t4_level", 32'(btn_level), 32'(5'b00010));

        // 4b. Reset while held: level drops with no release; held button re-presses once
        rst = 1'b1;
        tick();
        check("t4h_level", 32'(btn_level),   32'(0));
        check("t4h_rel",   32'(btn_release), 32'(0));
        check("t4h_press", 32'(btn_press),   32'(0));
        rst = 1'b0;
        wait_pulse("t4h_press", 1'b0, 5'b00010);
        btn_raw = 5'b00000;
        wait_pulse("t4h_release", 1'b1, 5'b00010);
        tick(3);

        // 5. Simultaneous press/release on several channels
        btn_raw = 5'b10101;
        wait_pulse("t5_press", 1'b0, 5'b10101);
        check("t5_level", 32'(btn_level), 32'(5'b10101));
        btn_raw = 5'b00000;
        wait_pulse("t5_release", 1'b1, 5'b10101);
        check("t5_level_off", 32'(btn_level), 32'(0));
        tick(3);

        // 6. Long hold: repeats only with AUTO_REPEAT_EN (press edge is k=0)
        btn_raw = 5'b00001;
        wait_pulse("t6_press", 1'b0, 5'b00001);
        for (int k = 2; k < 60; k++) begin
            tick();
`ifdef AUTO_REPEAT_EN
            exp_p = (k == 20 || k == 30 || k == 40 || k == 50) ? 5'b00001 : 5'b00000;
`else
            exp_p = 5'b00000;
`endif
            check($sformatf("t6_repeat_k%0d", k), 32'(btn_press), 32'(exp_p));
        end
        check("t6_level", 32'(btn_level), 32'(5'b00001));
        btn_raw = 5'b00000;
        wait_pulse("t6_release", 1'b1, 5'b00001);
        check("t6_level_off", 32'(btn_level), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
